txn_resp: RTL and testbench

Synthesizable responder for the fabric's `txn_*` transaction bus. It is the memory-side end of the protocol the fabric drives as initiator. It holds a preloadable read bank, which supplies the grid cost words, and a write bank, which receives the path words. Each request is served with a fixed, parameterized latency and a level-style `txn_rdy` handshake. It replaces behavioural memory models in FPGA builds and gives the host a load/readback port.

---
 rtl/txn_pkg.sv | 26 ++
 rtl/txn_resp_if.sv | 25 ++
 rtl/txn_resp_bank.sv | 25 ++
 rtl/txn_resp.sv | 164 ++++++++++++++++
 tb/tb_txn_resp.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/txn_pkg.sv
// txn_pkg: shared types and constants for the txn_resp transaction responder.
// Contents: default bank base addresses, FSM state enum, error read pattern,
// wait-counter width and the registered command payload struct.
package txn_pkg;

  localparam logic [31:0] TXN_RD_BASE  = 32'h4000_0000;
  localparam logic [31:0] TXN_WR_BASE  = 32'h4000_1000;
  localparam logic [31:0] TXN_ERR_DATA = 32'hDEAD_BEEF;

  // Wide enough for the largest supported latency (31).
  localparam int unsigned TXN_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } txn_state_t;

  // Address/data sampled every cycle so they line up with the edge pulses.
  typedef struct packed {
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } txn_cmd_t;

endpackage

// File: rtl/txn_resp_if.sv
// txn_resp_if: txn_* transaction bus between the fabric (initiator) and a responder.
// Signals: txn_req/txn_wr request and write qualifier, txn_raddr/txn_waddr byte
// addresses, txn_wdata write data, txn_rdata read data, txn_rdy ready level.
// Modports: master = initiator side, slave = responder side.
interface txn_resp_if;

  logic        txn_req;
  logic        txn_wr;
  logic [31:0] txn_raddr;
  logic [31:0] txn_waddr;
  logic [31:0] txn_wdata;
  logic [31:0] txn_rdata;
  logic        txn_rdy;

  modport master (
    output txn_req, txn_wr, txn_raddr, txn_waddr, txn_wdata,
    input  txn_rdata, txn_rdy
  );

  modport slave (
    input  txn_req, txn_wr, txn_raddr, txn_waddr, txn_wdata,
    output txn_rdata, txn_rdy
  );

endinterface

// File: rtl/txn_resp_bank.sv
// txn_resp_bank: DEPTH x 32 storage with one synchronous write port and one
// combinational read port. Contents are not reset.
// Ports: clk; we/waddr/wdata write port; raddr/rdata_c read port.
module txn_resp_bank #(
  parameter int unsigned DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata_c
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/txn_resp.sv
// txn_resp: memory-side responder for the txn_* bus. Serves reads from a
// host-preloadable read bank and writes into a host-readable write bank, each
// after a fixed LATENCY wait, with a level-style txn_rdy handshake.
// Ports: clk, arst (async, active high); bus (txn_resp_if.slave);
// host_ld/host_addr/host_data load the read bank (IDLE only);
// host_q is the write-bank word at host_addr (combinational);
// resp_overrun sticky request-while-busy flag; resp_err sticky range error.
// Config macro: TXN_RESP_ERR_EN enables out-of-range detection; without it
// indices wrap modulo DEPTH and resp_err is tied low.
module txn_resp
  import txn_pkg::*;
#(
  parameter int unsigned DEPTH   = 128,
  parameter logic [31:0] RD_BASE = TXN_RD_BASE,
  parameter logic [31:0] WR_BASE = TXN_WR_BASE,
  parameter int unsigned LATENCY = 16
) (
  input  logic                     clk,
  input  logic                     arst,
  txn_resp_if.slave                bus,
  input  logic                     host_ld,
  input  logic [$clog2(DEPTH)-1:0] host_addr,
  input  logic [31:0]              host_data,
  output logic [31:0]              host_q,
  output logic                     resp_overrun,
  output logic                     resp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  txn_state_t           state;
  logic [1:0]           req_ff;
  logic [1:0]           wr_ff;
  txn_cmd_t             cmd_d;
  logic [TXN_CNT_W-1:0] cnt;
  logic [AW-1:0]        idx_q;
  logic [31:0]          data_q;
  logic                 err_q;
  logic                 rdy_q;
  logic [31:0]          rdata_q;

  logic                 req_pulse;
  logic                 wr_pulse;
  logic [AW-1:0]        rd_idx;
  logic [AW-1:0]        wr_idx;
  logic                 rd_err;
  logic                 wr_err;
  logic                 acc_err;
  logic [31:0]          rd_word_c;
  logic                 rd_ld;
  logic                 wr_we;

  assign req_pulse = (req_ff == 2'b01);
  assign wr_pulse  = (wr_ff == 2'b01);

  // Word index from byte offset; only the low AW bits address the bank.
  assign rd_idx = AW'((cmd_d.raddr - RD_BASE) >> 2);
  assign wr_idx = AW'((cmd_d.waddr - WR_BASE) >> 2);

`ifdef TXN_RESP_ERR_EN
  // Any index bit above AW (base underflow included) is out of range.
  assign rd_err = |(((cmd_d.raddr - RD_BASE) >> 2) >> AW);
  assign wr_err = |(((cmd_d.waddr - WR_BASE) >> 2) >> AW);
`else
  assign rd_err = 1'b0;
  assign wr_err = 1'b0;
`endif

  assign acc_err = wr_pulse ? wr_err : rd_err;

  assign rd_ld = host_ld && (state == IDLE);
  assign wr_we = (state == WR_WAIT) && (cnt == '0) && !err_q;

  txn_resp_bank #(.DEPTH(DEPTH)) u_rd_bank (
    .clk     (clk),
    .we      (rd_ld),
    .waddr   (host_addr),
    .wdata   (host_data),
    .raddr   (rd_idx),
    .rdata_c (rd_word_c)
  );

  txn_resp_bank #(.DEPTH(DEPTH)) u_wr_bank (
    .clk     (clk),
    .we      (wr_we),
    .waddr   (idx_q),
    .wdata   (data_q),
    .raddr   (host_addr),
    .rdata_c (host_q)
  );

  // Edge detect, command capture and transaction FSM. The read word is
  // snapshotted at acceptance, so a host load on the same edge is not seen.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      req_ff       <= 2'b00;
      wr_ff        <= 2'b00;
      cmd_d        <= '0;
      state        <= IDLE;
      cnt          <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      rdy_q        <= 1'b1;
      rdata_q      <= '0;
      resp_overrun <= 1'b0;
    end else begin
      req_ff      <= {req_ff[0], bus.txn_req};
      wr_ff       <= {wr_ff[0], bus.txn_wr};
      cmd_d.raddr <= bus.txn_raddr;
      cmd_d.waddr <= bus.txn_waddr;
      cmd_d.wdata <= bus.txn_wdata;
      case (state)
        IDLE: begin
          if (req_pulse) begin
            cnt   <= TXN_CNT_W'(LATENCY);
            rdy_q <= 1'b0;
            err_q <= acc_err;
            if (wr_pulse) begin
              idx_q  <= wr_idx;
              data_q <= cmd_d.wdata;
              state  <= WR_WAIT;
            end else begin
              idx_q  <= rd_idx;
              data_q <= rd_word_c;
              state  <= RD_WAIT;
            end
          end
        end
        default: begin
          if (req_pulse) begin
            resp_overrun <= 1'b1;
          end
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (state == RD_WAIT) begin
              rdata_q <= err_q ? TXN_ERR_DATA : data_q;
            end
            rdy_q <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef TXN_RESP_ERR_EN
  // Sticky range error, flagged when the faulting request is accepted.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      resp_err <= 1'b0;
    end else if ((state == IDLE) && req_pulse && acc_err) begin
      resp_err <= 1'b1;
    end
  end
`else
  assign resp_err = 1'b0;
`endif

  assign bus.txn_rdy   = rdy_q;
  assign bus.txn_rdata = rdata_q;

endmodule

// File: tb/tb_txn_resp.sv
// tb_txn_resp: self-checking bench for txn_resp (default build, no
// TXN_RESP_ERR_EN). Directed table, hand-written corner sequences and
// randomized transactions against an array-based reference model.
module tb_txn_resp;
  import txn_pkg::*;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = 7;
  localparam int unsigned LAT   = 16;
  localparam logic [31:0] RB    = 32'h4000_0000;
  localparam logic [31:0] WB    = 32'h4000_1000;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          host_ld;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_data;
  logic [31:0]   host_q;
  logic          resp_overrun;
  logic          resp_err;

  txn_resp_if bus ();

  txn_resp #(
    .DEPTH   (DEPTH),
    .RD_BASE (RB),
    .WR_BASE (WB),
    .LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .bus          (bus),
    .host_ld      (host_ld),
    .host_addr    (host_addr),
    .host_data    (host_data),
    .host_q       (host_q),
    .resp_overrun (resp_overrun),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: bank images and last completed read.
  logic [31:0] rd_mem [DEPTH];
  logic [31:0] wr_mem [DEPTH];
  logic [31:0] last_rdata;

  typedef struct {
    string       name;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    int unsigned q_idx;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bank word index as the byte offset from base divided by 4, wrapped.
  function automatic int unsigned word_of(input logic [31:0] a, input logic [31:0] base);
    logic [31:0] off;
    off = a - base;
    return int'((off / 32'd4) % DEPTH);
  endfunction

  task automatic host_load(input int unsigned idx, input logic [31:0] d);
    host_ld   = 1'b1;
    host_addr = AW'(idx);
    host_data = d;
    tick();
    host_ld   = 1'b0;
    rd_mem[idx] = d;
  endtask

  // Count busy cycles until txn_rdy returns high, bounded.
  task automatic wait_done(input int low0, output int low);
    low = low0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!bus.txn_rdy) low++;
      else if (low > 0) break;
    end
  endtask

  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         output logic [31:0] rd, output int low);
    bus.txn_wr = wr;
    if (wr) bus.txn_waddr = addr;
    else    bus.txn_raddr = addr;
    bus.txn_wdata = data;
    bus.txn_req   = 1'b1;
    tick();
    bus.txn_req = 1'b0;
    bus.txn_wr  = 1'b0;
    wait_done(0, low);
    rd = bus.txn_rdata;
  endtask

  // Full transaction checked against the model.
  task automatic model_txn(input string name, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data);
    logic [31:0] rd;
    int low;
    int unsigned idx;
    run_txn(wr, addr, data, rd, low);
    chk({name, "_lat"}, 32'(low), 32'(LAT + 1));
    if (wr) begin
      idx = word_of(addr, WB);
      wr_mem[idx] = data;
      chk({name, "_hold"}, rd, last_rdata);
      host_addr = AW'(idx);
      #1;
      chk({name, "_q"}, host_q, wr_mem[idx]);
    end else begin
      idx = word_of(addr, RB);
      last_rdata = rd_mem[idx];
      chk({name, "_rd"}, rd, last_rdata);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] old;
    int low;
    int stay;

    bus.txn_req   = 1'b0;
    bus.txn_wr    = 1'b0;
    bus.txn_raddr = '0;
    bus.txn_waddr = '0;
    bus.txn_wdata = '0;
    host_ld       = 1'b0;
    host_addr     = '0;
    host_data     = '0;
    last_rdata    = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy",     32'(bus.txn_rdy), 32'd1);
    chk("rst_rdata",   bus.txn_rdata,    32'd0);
    chk("rst_overrun", 32'(resp_overrun), 32'd0);
    chk("rst_err",     32'(resp_err),     32'd0);
    @(negedge clk);
    arst = 1'b0;
    tick();

    for (int i = 0; i < DEPTH; i++) host_load(i, 32'hA500_0000 | 32'(i));
    host_load(5, 32'h0000_0123);

    vecs[0] = '{"rd_w5",    1'b0, 32'h4000_0014, 32'h0,         32'h0000_0123, 0};
    vecs[1] = '{"wr_w2",    1'b1, 32'h4000_1008, 32'hCAFE_0001, 32'hCAFE_0001, 2};
    vecs[2] = '{"rd_wrap",  1'b0, 32'h4000_0400, 32'h0,         32'hA500_0000, 0};
    vecs[3] = '{"rd_under", 1'b0, 32'h3FFF_FFFC, 32'h0,         32'hA500_007F, 0};
    vecs[4] = '{"wr_last",  1'b1, 32'h4000_11FC, 32'h1234_5678, 32'h1234_5678, 127};
    vecs[5] = '{"rd_first", 1'b0, 32'h4000_0000, 32'h0,         32'hA500_0000, 0};
    vecs[6] = '{"rd_last",  1'b0, 32'h4000_01FC, 32'h0,         32'hA500_007F, 0};
    vecs[7] = '{"wr_wrap",  1'b1, 32'h4000_1200, 32'h0BAD_F00D, 32'h0BAD_F00D, 0};
    vecs[8] = '{"rd_unal",  1'b0, 32'h4000_0017, 32'h0,         32'h0000_0123, 0};

    for (int v = 0; v < 9; v++) begin
      run_txn(vecs[v].wr, vecs[v].addr, vecs[v].data, rd, low);
      chk({vecs[v].name, "_lat"}, 32'(low), 32'(LAT + 1));
      if (vecs[v].wr) begin
        chk({vecs[v].name, "_hold"}, rd, last_rdata);
        host_addr = AW'(vecs[v].q_idx);
        #1;
        chk({vecs[v].name, "_q"}, host_q, vecs[v].exp);
        wr_mem[vecs[v].q_idx] = vecs[v].data;
      end else begin
        chk({vecs[v].name, "_rd"}, rd, vecs[v].exp);
        last_rdata = vecs[v].exp;
      end
    end

    // Host load on the same edge that accepts a read of that word.
    old = rd_mem[9];
    bus.txn_raddr = RB + 32'd36;
    bus.txn_req   = 1'b1;
    tick();
    bus.txn_req = 1'b0;
    host_ld     = 1'b1;
    host_addr   = AW'(9);
    host_data   = 32'h5555_AAAA;
    tick();
    host_ld = 1'b0;
    rd_mem[9] = 32'h5555_AAAA;
    wait_done(1, low);
    chk("ld_same_lat", 32'(low), 32'(LAT + 1));
    chk("ld_same_old", bus.txn_rdata, old);
    last_rdata = old;
    model_txn("ld_same_new", 1'b0, RB + 32'd36, 32'h0);

    // Randomized mix of host loads, reads and writes.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      bit w;
      if ($urandom_range(3) == 0) host_load($urandom_range(DEPTH - 1), $urandom);
      w = 1'($urandom_range(1));
      if ($urandom_range(7) == 0) a = $urandom;
      else a = (w ? WB : RB) + 32'($urandom_range(255)) * 32'd4 + 32'($urandom_range(3));
      model_txn(w ? "rnd_wr" : "rnd_rd", w, a, $urandom);
    end

    // Back-to-back reads at minimum spacing.
    for (int i = 0; i < DEPTH; i++) model_txn("b2b", 1'b0, RB + 32'(i) * 32'd4, 32'h0);
    chk("b2b_overrun", 32'(resp_overrun), 32'd0);

    // Second request edge five cycles into a read.
    bus.txn_raddr = RB + 32'd80;
    bus.txn_req   = 1'b1;
    tick();
    bus.txn_req = 1'b0;
    repeat (5) tick();
    bus.txn_raddr = RB + 32'd84;
    bus.txn_req   = 1'b1;
    tick();
    bus.txn_req = 1'b0;
    wait_done(6, low);
    chk("ovr_lat",  32'(low), 32'(LAT + 1));
    chk("ovr_data", bus.txn_rdata, rd_mem[20]);
    chk("ovr_flag", 32'(resp_overrun), 32'd1);
    last_rdata = rd_mem[20];
    stay = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus.txn_rdy) stay++;
    end
    chk("ovr_dropped", 32'(stay), 32'd0);

    // Reset during a write wait.
    bus.txn_waddr = WB + 32'd8;
    bus.txn_wdata = 32'hFFFF_0000;
    bus.txn_wr    = 1'b1;
    bus.txn_req   = 1'b1;
    tick();
    bus.txn_req = 1'b0;
    bus.txn_wr  = 1'b0;
    repeat (4) tick();
    chk("mid_busy", 32'(bus.txn_rdy), 32'd0);
    #2;
    arst = 1'b1;
    #1;
    chk("mid_rdy",     32'(bus.txn_rdy), 32'd1);
    chk("mid_overrun", 32'(resp_overrun), 32'd0);
    @(negedge clk);
    arst = 1'b0;
    last_rdata = '0;
    repeat (LAT + 4) tick();
    host_addr = AW'(2);
    #1;
    chk("mid_word", host_q, wr_mem[2]);
    model_txn("post_rst", 1'b0, RB + 32'd20, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
